// File: rtl/maze_cell_store.sv
// Maze cell store: 1 bit per cell (1 = wall), written by the generator and read by the
// display path with a fixed 2-cycle pipelined latency, plus a built-in clear sequencer.
module maze_cell_store #(
  parameter int   WIDTH      = 30,
  parameter int   HEIGHT     = 40,
  parameter int   ADDR_W     = 11,
  parameter logic INIT_VALUE = 1'b1
) (
  input  logic              clock,
  input  logic              resetApp,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              rd_data,
  output logic              rd_oob
);

  localparam int                N    = WIDTH * HEIGHT;
  localparam logic [ADDR_W:0]   N_W  = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              done_nxt;

  logic              mem [N];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_din;

  logic              vld_p1;
  logic              oob_p1;
  logic              data_p1;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < N_W;
  endfunction

  // A new init_start always wins, so a pass in progress restarts without a done pulse.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    if (init_start) begin
      state_nxt = CLEAR;
      cnt_nxt   = '0;
    end else if (state == CLEAR) begin
      if (cnt == LAST) begin
        state_nxt = READY;
        done_nxt  = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state     <= IDLE;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_done <= done_nxt;
    end
  end

  assign init_busy = (state == CLEAR);

  // Single write port shared by the clear sequencer and the generator.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = 1'b0;
    if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = cnt;
      mem_din  = INIT_VALUE;
    end else if (state == READY && wr_en && in_range(wr_addr)) begin
      mem_we   = 1'b1;
      mem_addr = wr_addr;
      mem_din  = wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end

  // Stage 1: register flags and sample the array on the request edge (read-first).
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
    end
  end

  always_ff @(posedge clock) begin
    if (rd_en) begin
      oob_p1  <= !in_range(rd_addr);
      data_p1 <= (state == READY && in_range(rd_addr)) ? mem[rd_addr] : INIT_VALUE;
    end
  end

  // Stage 2: output registers hold their last response while rd_valid is low.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      rd_valid <= 1'b0;
      rd_data  <= 1'b0;
      rd_oob   <= 1'b0;
    end else begin
      rd_valid <= vld_p1;
      if (vld_p1) begin
        rd_data <= data_p1;
        rd_oob  <= oob_p1;
      end
    end
  end

endmodule
